// File: rtl/megszakitas_vezerlo.sv
// 8-input prioritised interrupt controller: rising-edge capture, masking,
// nesting by in-service priority, ack/vector handshake and EOI.
module megszakitas_vezerlo #(
  parameter bit AUTO_EOI = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  input  logic [7:0] mask,
  input  logic       ack,
  input  logic       eoi,
  output logic       int_out,
  output logic [2:0] vec,
  output logic       vec_valid,
  output logic [7:0] pending,
  output logic [7:0] in_service
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t     state_q, state_d;
  logic [7:0] irq_prev_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] in_service_q, in_service_d;
  logic [7:0] cand;
  logic [2:0] hp, his;
  logic       his_vld, eligible, take;
  logic [2:0] vec_q, vec_d;
  logic       vv_q, vv_d;
  logic       int_q, int_d;

  // Ascending scan: the last set bit seen is the highest priority one.
  always_comb begin
    cand    = pending_q & ~mask;
    hp      = 3'd0;
    his     = 3'd0;
    his_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) hp = 3'(i);
      if (in_service_q[i]) begin
        his     = 3'(i);
        his_vld = 1'b1;
      end
    end
    eligible = (cand != 8'd0) && (!his_vld || hp > his);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (eligible) state_d = REQ;
      REQ:  if (ack || !eligible) state_d = IDLE;
    endcase
  end

  // hp is re-evaluated at ack time, so a later higher source wins.
  always_comb begin
    take  = (state_q == REQ) && ack && eligible;
    int_d = (state_d == REQ);
    vv_d  = take;
    vec_d = take ? hp : vec_q;
  end

  // EOI acts on the pre-edge in-service set; the ack's set is applied after.
  always_comb begin
    pending_d = pending_q;
    if (take) pending_d[hp] = 1'b0;
    pending_d = pending_d | (irq & ~irq_prev_q);
    in_service_d = in_service_q;
    if (!AUTO_EOI) begin
      if (eoi && his_vld) in_service_d[his] = 1'b0;
      if (take)           in_service_d[hp]  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q   <= 8'd0;
      pending_q    <= 8'd0;
      in_service_q <= 8'd0;
      vec_q        <= 3'd0;
      vv_q         <= 1'b0;
      int_q        <= 1'b0;
    end else begin
      irq_prev_q   <= irq;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      vec_q        <= vec_d;
      vv_q         <= vv_d;
      int_q        <= int_d;
    end
  end

  assign int_out    = int_q;
  assign vec        = vec_q;
  assign vec_valid  = vv_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_megszakitas_vezerlo.sv
// Bench for megszakitas_vezerlo: two instances (AUTO_EOI=0/1) on shared inputs,
// per-cycle expected snapshots from a rule-level model, popped by a monitor.
module tb_megszakitas_vezerlo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq, mask;
  logic       ack, eoi;
  logic       o_int  [2];
  logic [2:0] o_vec  [2];
  logic       o_vv   [2];
  logic [7:0] o_pend [2];
  logic [7:0] o_isv  [2];

  always #5 clk = ~clk;

  megszakitas_vezerlo #(.AUTO_EOI(1'b0)) dut (
    .clk(clk), .rst(rst), .irq(irq), .mask(mask), .ack(ack), .eoi(eoi),
    .int_out(o_int[0]), .vec(o_vec[0]), .vec_valid(o_vv[0]),
    .pending(o_pend[0]), .in_service(o_isv[0]));

  megszakitas_vezerlo #(.AUTO_EOI(1'b1)) dut_a (
    .clk(clk), .rst(rst), .irq(irq), .mask(mask), .ack(ack), .eoi(eoi),
    .int_out(o_int[1]), .vec(o_vec[1]), .vec_valid(o_vv[1]),
    .pending(o_pend[1]), .in_service(o_isv[1]));

  typedef struct {
    logic [7:0] pend, isv, prev;
    logic       intq, vv;
    logic [2:0] vec;
  } mdl_t;

  typedef struct {
    logic [7:0] pend, isv;
    logic       io, vv;
    logic [2:0] vec;
  } exp_t;

  mdl_t m [2];
  exp_t sbq [2][$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int msb(input logic [7:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic mreset(input int k);
    m[k] = '{pend: 8'd0, isv: 8'd0, prev: 8'd0, intq: 1'b0, vv: 1'b0, vec: 3'd0};
  endtask

  // One clock of the controller's rules, for instance k (k==1 is AUTO_EOI).
  task automatic mstep(input int k);
    mdl_t       s;
    logic [7:0] cand;
    int         hp, his;
    bit         au, elig, take;
    s    = m[k];
    au   = (k == 1);
    cand = s.pend & ~mask;
    hp   = msb(cand);
    his  = msb(s.isv);
    elig = (cand != 8'd0) && (hp > his);
    take = s.intq && ack && elig;
    s.vv = take;
    if (take) s.vec = 3'(hp);
    if (!au && eoi && his >= 0) s.isv[his] = 1'b0;
    if (take) begin
      s.pend[hp] = 1'b0;
      if (!au) s.isv[hp] = 1'b1;
    end
    s.pend = s.pend | (irq & ~s.prev);
    s.prev = irq;
    s.intq = elig && !take;
    m[k] = s;
  endtask

  function automatic exp_t snap(input int k);
    return '{pend: m[k].pend, isv: m[k].isv, io: m[k].intq, vv: m[k].vv, vec: m[k].vec};
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) mreset(k);
      else     mstep(k);
      sbq[k].push_back(snap(k));
    end
    #1;
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    logic prev_vv [2];
    exp_t e;
    prev_vv[0] = 1'b0;
    prev_vv[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (sbq[k].size() > 0) begin
          e = sbq[k].pop_front();
          chk($sformatf("snap%0d{pend,isv,int,vv,vec}", k),
              {11'd0, o_pend[k], o_isv[k], o_int[k], o_vv[k], o_vec[k]},
              {11'd0, e.pend, e.isv, e.io, e.vv, e.vec});
        end
        if (o_vv[k] === 1'b1) chk($sformatf("vv_twice%0d", k), {31'd0, prev_vv[k]}, 32'd0);
        prev_vv[k] = o_vv[k];
      end
    end
  end

  initial begin
    int mchg;
    rst = 1'b1; irq = 8'd0; mask = 8'd0; ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_int", {31'd0, o_int[0]}, 32'd0);

    // 1: single source
    irq = 8'h10; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_vec", o_vec[0], 4);
    chk("t1_vv", o_vv[0], 1);
    chk("t1_isv", o_isv[0], 8'h10);
    chk("auto_vec", o_vec[1], 4);
    chk("auto_isv", o_isv[1], 0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h00; tick();

    // 2: two simultaneous sources served in priority order
    irq = 8'h21; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_vec5", o_vec[0], 5);
    chk("t2_isv20", o_isv[0], 8'h20);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t2_isv0", o_isv[0], 0);
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_vec0", o_vec[0], 0);
    chk("t2_isv01", o_isv[0], 8'h01);
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h00; tick();

    // 3: nesting
    irq = 8'h04; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    irq = 8'h44; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t3_vec6", o_vec[0], 6);
    chk("t3_isv44", o_isv[0], 8'h44);
    irq = 8'h46; tick(); tick(); tick();
    chk("t3_blocked", o_int[0], 0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    chk("t3_blocked2", o_int[0], 0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    chk("t3_int", o_int[0], 1);
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h00; tick();

    // 4: masking
    mask = 8'h08; irq = 8'h08; tick(); tick();
    chk("t4_pend", o_pend[0], 8'h08);
    chk("t4_int0", o_int[0], 0);
    mask = 8'h00; tick();
    chk("t4_int1", o_int[0], 1);
    mask = 8'h08; tick();
    chk("t4_drop", o_int[0], 0);
    chk("t4_novv", o_vv[0], 0);
    mask = 8'h00; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t4_vec3", o_vec[0], 3);
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h00; tick();

    // 5: idle ack, ack+eoi together, irq edge racing an ack
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t5_idle_vv", o_vv[0], 0);
    chk("t5_idle_isv", o_isv[0], 0);
    irq = 8'h04; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    irq = 8'h84; tick(); tick();
    ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
    chk("t5_ackeoi", o_isv[0], 8'h80);
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h20; tick();
    irq = 8'h00; tick();
    irq = 8'h20; ack = 1'b1; tick(); ack = 1'b0;
    chk("t5_setwins", o_pend[0], 8'h20);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h00; tick();

    // 6: asynchronous reset in REQ with in_service=03
    irq = 8'h01; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    irq = 8'h03; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t6_isv03", o_isv[0], 8'h03);
    irq = 8'h07; tick(); tick();
    chk("t6_req", o_int[0], 1);
    rst = 1'b1; #1;
    chk("t6_async0", {o_pend[0], o_isv[0], o_int[0], o_vv[0], o_vec[0]}, 0);
    chk("t6_async1", {o_pend[1], o_isv[1], o_int[1], o_vv[1], o_vec[1]}, 0);
    for (int k = 0; k < 2; k++) begin
      mreset(k);
      sbq[k].delete();
      sbq[k].push_back(snap(k));
    end
    tick();
    rst = 1'b0;
    tick();
    chk("t6_high_at_release", o_pend[0], 8'h07);

    // random traffic; mask changes never coincide with an ack
    for (int n = 0; n < 400; n++) begin
      irq  = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mchg = $urandom_range(0, 15);
      if (mchg == 0) mask = 8'($urandom) & 8'($urandom);
      ack  = (mchg != 0) && ($urandom_range(0, 2) == 0);
      eoi  = ($urandom_range(0, 5) == 0);
      tick();
    end
    ack = 1'b0; eoi = 1'b0; irq = 8'h00;
    tick(); tick(); tick();
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
